// File: rtl/accelerator_pkg.sv
// Shared types and limits for the OBI data-port arbiter and its route FIFO.
package accelerator_pkg;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_VEC  = 2'd2
  } arb_id_t;

  localparam int MAX_OUTSTANDING_LIMIT = 4;
  localparam int CNT_W                 = 3;
  localparam int PTR_W                 = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/obi_route_fifo.sv
// In-order FIFO of requester IDs: one entry per accepted-but-unanswered transaction.
module obi_route_fifo
  import accelerator_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  arb_id_t          push_id,
  input  logic             pop,
  output arb_id_t          head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  arb_id_t          slot_val [MAX_OUTSTANDING_LIMIT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = slot_val[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slots beyond DEPTH exist only to keep the pointer index full-width; they are never written.
  for (genvar gi = 0; gi < MAX_OUTSTANDING_LIMIT; gi++) begin : g_slot
    arb_id_t slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (do_push && (wr_ptr_q == PTR_W'(gi)) && (gi < DEPTH)) begin
        slot_d = push_id;
      end
    end

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        slot_q <= ARB_NONE;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign slot_val[gi] = slot_q;
  end

endmodule

// File: rtl/obi_data_arbiter.sv
// Shares one OBI data master port between the core LSU (C) and vector LSU (V).
// Optional stall counters are enabled by defining ARB_PERF_COUNTERS_EN.
module obi_data_arbiter
  import accelerator_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        c_req_i,
  output logic        c_gnt_o,
  input  logic [31:0] c_addr_i,
  input  logic        c_we_i,
  input  logic [3:0]  c_be_i,
  input  logic [31:0] c_wdata_i,
  output logic        c_rvalid_o,
  output logic [31:0] c_rdata_o,
  input  logic        v_req_i,
  output logic        v_gnt_o,
  input  logic [31:0] v_addr_i,
  input  logic        v_we_i,
  input  logic [3:0]  v_be_i,
  input  logic [31:0] v_wdata_i,
  output logic        v_rvalid_o,
  output logic [31:0] v_rdata_o,
  input  logic        v_lock_i,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
`ifdef ARB_PERF_COUNTERS_EN
  output logic [31:0] c_stall_cnt_o,
  output logic [31:0] v_stall_cnt_o,
`endif
  output logic        err_o
);

  localparam int DEPTH = (MAX_OUTSTANDING < 1) ? 1 :
                         (MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) ? MAX_OUTSTANDING_LIMIT :
                         MAX_OUTSTANDING;

  arb_id_t          owner_q, owner_d;
  arb_id_t          last_q, last_d;
  arb_id_t          winner, sel, fifo_head;
  logic             err_q, err_d;
  logic             sel_req, handshake;
  logic             fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;

  always_comb begin
    winner = ARB_NONE;
    if (c_req_i && v_req_i) begin
      if (v_lock_i && (last_q == ARB_VEC)) begin
        winner = ARB_VEC;
      end else begin
        winner = (last_q == ARB_CORE) ? ARB_VEC : ARB_CORE;
      end
    end else if (c_req_i) begin
      winner = ARB_CORE;
    end else if (v_req_i) begin
      winner = ARB_VEC;
    end
    sel = (owner_q != ARB_NONE) ? owner_q : winner;
  end

  always_comb begin
    sel_req   = 1'b0;
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    case (sel)
      ARB_CORE: begin
        sel_req   = c_req_i;
        m_addr_o  = c_addr_i;
        m_we_o    = c_we_i;
        m_be_o    = c_be_i;
        m_wdata_o = c_wdata_i;
      end
      ARB_VEC: begin
        sel_req   = v_req_i;
        m_addr_o  = v_addr_i;
        m_we_o    = v_we_i;
        m_be_o    = v_be_i;
        m_wdata_o = v_wdata_i;
      end
      default: ;
    endcase
  end

  // Forwarding depends only on the registered FIFO level, never on this cycle's response.
  assign m_req_o   = sel_req && !fifo_full;
  assign handshake = m_req_o && m_gnt_i;
  assign c_gnt_o   = handshake && (sel == ARB_CORE);
  assign v_gnt_o   = handshake && (sel == ARB_VEC);

  assign fifo_pop   = m_rvalid_i && (fifo_count != '0);
  assign c_rvalid_o = fifo_pop && (fifo_head == ARB_CORE);
  assign v_rvalid_o = fifo_pop && (fifo_head == ARB_VEC);
  assign c_rdata_o  = c_rvalid_o ? m_rdata_i : '0;
  assign v_rdata_o  = v_rvalid_o ? m_rdata_i : '0;
  assign err_o      = err_q;

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q || (m_rvalid_i && fifo_empty);
    if ((owner_q != ARB_NONE) && !sel_req) begin
      owner_d = ARB_NONE;
    end else if (handshake) begin
      owner_d = ARB_NONE;
      last_d  = sel;
    end else if (m_req_o) begin
      owner_d = sel;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      owner_q <= ARB_NONE;
      last_q  <= ARB_CORE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  obi_route_fifo #(
    .DEPTH (DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (handshake),
    .push_id (sel),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifdef ARB_PERF_COUNTERS_EN
  logic [1:0]  stall_req, stall_gnt;
  logic [31:0] stall_cnt [2];

  assign stall_req = {v_req_i, c_req_i};
  assign stall_gnt = {v_gnt_o, c_gnt_o};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stall
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (stall_req[gi] && !stall_gnt[gi]) begin
        cnt_d = sat_inc(cnt_q);
      end
    end

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stall_cnt[gi] = cnt_q;
  end

  assign c_stall_cnt_o = stall_cnt[0];
  assign v_stall_cnt_o = stall_cnt[1];
`endif

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Scoreboard bench for obi_data_arbiter: expected route IDs are queued at grant, checked at rvalid.
module tb_obi_data_arbiter;

  logic        clk;
  logic        n_reset;
  logic        c_req_i, c_gnt_o, c_we_i, c_rvalid_o;
  logic [31:0] c_addr_i, c_wdata_i, c_rdata_o;
  logic [3:0]  c_be_i;
  logic        v_req_i, v_gnt_o, v_we_i, v_rvalid_o, v_lock_i;
  logic [31:0] v_addr_i, v_wdata_i, v_rdata_o;
  logic [3:0]  v_be_i;
  logic        m_req_o, m_gnt_i, m_we_o, m_rvalid_i, err_o;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [3:0]  m_be_o;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] c_stall_cnt_o, v_stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  obi_data_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .n_reset(n_reset),
    .c_req_i(c_req_i), .c_gnt_o(c_gnt_o), .c_addr_i(c_addr_i), .c_we_i(c_we_i),
    .c_be_i(c_be_i), .c_wdata_i(c_wdata_i), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .v_req_i(v_req_i), .v_gnt_o(v_gnt_o), .v_addr_i(v_addr_i), .v_we_i(v_we_i),
    .v_be_i(v_be_i), .v_wdata_i(v_wdata_i), .v_rvalid_o(v_rvalid_o), .v_rdata_o(v_rdata_o),
    .v_lock_i(v_lock_i), .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o),
    .m_we_o(m_we_o), .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i),
`ifdef ARB_PERF_COUNTERS_EN
    .c_stall_cnt_o(c_stall_cnt_o), .v_stall_cnt_o(v_stall_cnt_o),
`endif
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req_i = 0; v_req_i = 0; v_lock_i = 0; m_gnt_i = 0; m_rvalid_i = 0;
    c_we_i = 0; v_we_i = 1; c_be_i = 4'hF; v_be_i = 4'h3;
    c_wdata_i = 32'h0C0C_0C0C; v_wdata_i = 32'h0A0A_0A0A; m_rdata_i = 0;
  endtask

  task automatic test_reset();
    idle();
    c_addr_i = 0; v_addr_i = 0;
    n_reset = 1;
    #1 n_reset = 0;
    #2;
    checks++;
    if ({m_req_o, c_gnt_o, v_gnt_o, c_rvalid_o, v_rvalid_o, err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {m_req_o, c_gnt_o, v_gnt_o, c_rvalid_o, v_rvalid_o, err_o});
    end
    repeat (2) @(posedge clk);
    #1 n_reset = 1;
    step();
  endtask

  task automatic test_core_alone();
    int id;
    c_req_i = 1; c_addr_i = 32'h100; m_gnt_i = 1;
    #2;
    checks++;
    if (m_req_o !== 1 || m_addr_o !== 32'h100 || m_we_o !== 0 || m_be_o !== 4'hF) begin
      errors++;
      $display("FAIL core_addr_phase: req=%b addr=%h we=%b be=%h want 1 00000100 0 f",
               m_req_o, m_addr_o, m_we_o, m_be_o);
    end
    checks++;
    if (c_gnt_o !== 1 || v_gnt_o !== 0) begin
      errors++;
      $display("FAIL core_gnt: c_gnt=%b v_gnt=%b want 1 0", c_gnt_o, v_gnt_o);
    end
    exp_q.push_back(1);
    step();
    c_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'hDEADBEEF;
    #2;
    id = exp_q.pop_front();
    checks++;
    if (c_rvalid_o !== (id == 1) || v_rvalid_o !== (id == 2) || c_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_resp: c_rvalid=%b v_rvalid=%b c_rdata=%h want id %0d rdata deadbeef",
               c_rvalid_o, v_rvalid_o, c_rdata_o, id);
    end
    $display("core_alone: resp c_rdata=%h", c_rdata_o);
    step();
    idle();
  endtask

  task automatic test_alternation();
    logic exp_v;
    int id;
    logic [31:0] got;
    c_addr_i = 32'h200; v_addr_i = 32'h300;
    for (int i = 0; i < 5; i++) begin
      c_req_i = (i < 4); v_req_i = (i < 4); m_gnt_i = (i < 4);
      m_rvalid_i = (exp_q.size() != 0); m_rdata_i = 32'h1000 + i;
      #2;
      if (m_rvalid_i) begin
        id = exp_q.pop_front();
        got = (id == 1) ? c_rdata_o : v_rdata_o;
        checks++;
        if (c_rvalid_o !== (id == 1) || v_rvalid_o !== (id == 2) || got !== m_rdata_i) begin
          errors++;
          $display("FAIL alt_resp[%0d]: c_rvalid=%b v_rvalid=%b rdata=%h want id %0d rdata %h",
                   i, c_rvalid_o, v_rvalid_o, got, id, m_rdata_i);
        end
      end
      if (i < 4) begin
        exp_v = (i % 2 == 0);
        checks++;
        if (v_gnt_o !== exp_v || c_gnt_o !== !exp_v || m_addr_o !== (exp_v ? v_addr_i : c_addr_i)) begin
          errors++;
          $display("FAIL alt_gnt[%0d]: c_gnt=%b v_gnt=%b addr=%h want v_gnt %b",
                   i, c_gnt_o, v_gnt_o, m_addr_o, exp_v);
        end
        exp_q.push_back(exp_v ? 2 : 1);
        $display("alternation[%0d]: granted %s", i, exp_v ? "V" : "C");
      end
      step();
    end
    idle();
  endtask

  task automatic test_lock();
    logic exp_v;
    int id;
    for (int i = 0; i < 6; i++) begin
      c_req_i = (i < 5); v_req_i = (i < 5); v_lock_i = (i < 4); m_gnt_i = (i < 5);
      m_rvalid_i = (exp_q.size() != 0); m_rdata_i = 32'h2000 + i;
      #2;
      if (m_rvalid_i) begin
        id = exp_q.pop_front();
        checks++;
        if (c_rvalid_o !== (id == 1) || v_rvalid_o !== (id == 2)) begin
          errors++;
          $display("FAIL lock_resp[%0d]: c_rvalid=%b v_rvalid=%b want id %0d",
                   i, c_rvalid_o, v_rvalid_o, id);
        end
      end
      if (i < 5) begin
        exp_v = (i < 4);
        checks++;
        if (v_gnt_o !== exp_v || c_gnt_o !== !exp_v) begin
          errors++;
          $display("FAIL lock_gnt[%0d]: c_gnt=%b v_gnt=%b want v_gnt %b", i, c_gnt_o, v_gnt_o, exp_v);
        end
        exp_q.push_back(exp_v ? 2 : 1);
        $display("lock[%0d]: granted %s", i, exp_v ? "V" : "C");
      end
      step();
    end
    idle();
  endtask

  task automatic test_hold();
    int id;
    c_addr_i = 32'h400; v_addr_i = 32'h500;
    for (int i = 0; i < 6; i++) begin
      c_req_i = (i < 4); v_req_i = (i >= 2 && i < 5); m_gnt_i = (i >= 3 && i < 5);
      m_rvalid_i = (exp_q.size() != 0); m_rdata_i = 32'hCAFE_0000 + i;
      #2;
      if (m_rvalid_i) begin
        id = exp_q.pop_front();
        checks++;
        if (c_rvalid_o !== (id == 1) || v_rvalid_o !== (id == 2)) begin
          errors++;
          $display("FAIL hold_resp[%0d]: c_rvalid=%b v_rvalid=%b want id %0d",
                   i, c_rvalid_o, v_rvalid_o, id);
        end
      end
      if (i < 4) begin
        checks++;
        if (m_req_o !== 1 || m_addr_o !== 32'h400 || c_gnt_o !== (i == 3) || v_gnt_o !== 0) begin
          errors++;
          $display("FAIL hold_c[%0d]: req=%b addr=%h c_gnt=%b v_gnt=%b want 1 00000400 %b 0",
                   i, m_req_o, m_addr_o, c_gnt_o, v_gnt_o, (i == 3));
        end
        if (i == 3) exp_q.push_back(1);
      end
      if (i == 4) begin
        checks++;
        if (v_gnt_o !== 1 || m_addr_o !== 32'h500) begin
          errors++;
          $display("FAIL hold_v: v_gnt=%b addr=%h want 1 00000500", v_gnt_o, m_addr_o);
        end
        exp_q.push_back(2);
`ifdef ARB_PERF_COUNTERS_EN
        checks++;
        if (v_stall_cnt_o !== 32'd5 || c_stall_cnt_o !== 32'd9) begin
          errors++;
          $display("FAIL stall_cnt: c=%0d v=%0d want 9 5", c_stall_cnt_o, v_stall_cnt_o);
        end
`endif
      end
      $display("hold[%0d]: m_req=%b m_addr=%h", i, m_req_o, m_addr_o);
      step();
    end
    idle();
  endtask

  task automatic test_full();
    int id;
    // Per cycle: c_req, v_req, gnt, rvalid, expected m_req, expected c_gnt, expected v_gnt
    logic [6:0] tbl [7];
    tbl[0] = 7'b1010_110; tbl[1] = 7'b0110_101; tbl[2] = 7'b1010_000;
    tbl[3] = 7'b1011_000; tbl[4] = 7'b1010_110; tbl[5] = 7'b0001_000;
    tbl[6] = 7'b0001_000;
    c_addr_i = 32'h600; v_addr_i = 32'h700;
    for (int i = 0; i < 7; i++) begin
      c_req_i = tbl[i][6]; v_req_i = tbl[i][5]; m_gnt_i = tbl[i][4]; m_rvalid_i = tbl[i][3];
      m_rdata_i = 32'h3000 + i;
      #2;
      checks++;
      if ({m_req_o, c_gnt_o, v_gnt_o} !== tbl[i][2:0]) begin
        errors++;
        $display("FAIL full_req[%0d]: req/c_gnt/v_gnt=%b want %b", i, {m_req_o, c_gnt_o, v_gnt_o}, tbl[i][2:0]);
      end
      if (m_rvalid_i) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL full_sb[%0d]: response with no expected entry got 1 want 0", i);
        end else begin
          id = exp_q.pop_front();
          checks++;
          if (c_rvalid_o !== (id == 1) || v_rvalid_o !== (id == 2)) begin
            errors++;
            $display("FAIL full_resp[%0d]: c_rvalid=%b v_rvalid=%b want id %0d",
                     i, c_rvalid_o, v_rvalid_o, id);
          end
        end
      end
      if (tbl[i][1]) exp_q.push_back(1);
      if (tbl[i][0]) exp_q.push_back(2);
      $display("full[%0d]: m_req=%b c_gnt=%b v_gnt=%b", i, m_req_o, c_gnt_o, v_gnt_o);
      step();
    end
    idle();
  endtask

  task automatic test_err();
    checks++;
    if (err_o !== 0) begin
      errors++;
      $display("FAIL err_clear: got %b want 0", err_o);
    end
    m_rvalid_i = 1; m_rdata_i = 32'h5555_5555;
    #2;
    checks++;
    if (c_rvalid_o !== 0 || v_rvalid_o !== 0) begin
      errors++;
      $display("FAIL err_no_route: c_rvalid=%b v_rvalid=%b want 0 0", c_rvalid_o, v_rvalid_o);
    end
    step();
    m_rvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (err_o !== 1) begin
        errors++;
        $display("FAIL err_sticky[%0d]: got %b want 1", i, err_o);
      end
      $display("err[%0d]: err_o=%b", i, err_o);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_core_alone();
    test_alternation();
    test_lock();
    test_hold();
    test_full();
    test_err();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
